// File: rtl/gpio_switch_led_ctrl_if.sv
// Switch/LED channel bundle between the board-facing controller and its user.
// The master drives raw switches and mode; the slave (the controller) returns the conditioned views.
interface gpio_switch_led_ctrl_if #(
  parameter int unsigned NCH = 4
);
  logic [NCH-1:0] gpio_switch;
  logic [1:0]     led_mode;
  logic [NCH-1:0] gpio_led;
  logic [NCH-1:0] sw_level;
  logic [NCH-1:0] sw_rise;
  logic [NCH-1:0] sw_fall;

  modport master (
    output gpio_switch,
    output led_mode,
    input  gpio_led,
    input  sw_level,
    input  sw_rise,
    input  sw_fall
  );

  modport slave (
    input  gpio_switch,
    input  led_mode,
    output gpio_led,
    output sw_level,
    output sw_rise,
    output sw_fall
  );
endinterface

// File: rtl/gpio_switch_led_ctrl.sv
// N-channel switch conditioner: synchronise, debounce, edge-detect, and drive LEDs in one of
// four modes (mirror, toggle, blink, press counter).
module gpio_switch_led_ctrl #(
  parameter int unsigned NCH             = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned BLINK_DIV       = 25000000
) (
  input logic                   SYSTEMCLOCK,
  input logic                   PUSH_BUTTON_RESET_RAW,
  gpio_switch_led_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned DivW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivMax = DivW'(BLINK_DIV - 1);

  logic [NCH-1:0]  r_sync [SYNC_STAGES];
  logic [NCH-1:0]  w_s;
  logic [CntW-1:0] r_cnt [NCH];
  logic [CntW-1:0] w_cnt_d [NCH];
  logic [NCH-1:0]  r_level, w_level_d;
  logic [NCH-1:0]  r_rise, w_rise_d;
  logic [NCH-1:0]  r_fall, w_fall_d;
  logic [NCH-1:0]  r_tog;
  logic [NCH-1:0]  r_pcnt;
  logic [NCH-1:0]  r_led, w_led_d;
  logic [DivW-1:0] r_div;
  logic            r_blink;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= bus.gpio_switch;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  // A channel flips only after the synchronised input has disagreed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    w_level_d = r_level;
    w_rise_d  = '0;
    w_fall_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_cnt_d[i] = '0;
      if (w_s[i] != r_level[i]) begin
        if (r_cnt[i] == CntMax) begin
          w_level_d[i] = w_s[i];
          w_rise_d[i]  = w_s[i];
          w_fall_d[i]  = ~w_s[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= w_cnt_d[i];
      r_level <= w_level_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
    end
  end

  always_comb begin
    w_led_d = r_level;
    case (bus.led_mode)
      2'b01:   w_led_d = r_tog;
      2'b10:   w_led_d = r_level & {NCH{r_blink}};
      2'b11:   w_led_d = r_pcnt;
      default: w_led_d = r_level;
    endcase
  end

  // Press counter advances once per cycle with any rising edge, however many channels rose.
  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      r_tog   <= '0;
      r_pcnt  <= '0;
      r_div   <= '0;
      r_blink <= 1'b0;
      r_led   <= '0;
    end else begin
      r_tog <= r_tog ^ r_rise;
      if (|r_rise) r_pcnt <= r_pcnt + NCH'(1);
      if (r_div == DivMax) begin
        r_div   <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_div <= r_div + DivW'(1);
      end
      r_led <= w_led_d;
    end
  end

  assign bus.gpio_led = r_led;
  assign bus.sw_level = r_level;
  assign bus.sw_rise  = r_rise;
  assign bus.sw_fall  = r_fall;

endmodule
